// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and pipeline register layouts for fetch_decode_pipe
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int RS1_HI = 19;
    localparam int RS1_LO = 15;
    localparam int RS2_HI = 24;
    localparam int RS2_LO = 20;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 7;

    typedef struct packed {
        logic regwrite;
        logic resultsrc;
        logic memwrite;
        logic branch;
        logic jump;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } ifid_t;

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] immext;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } idex_t;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic pipeline register with clear-over-enable priority
module pipe_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] clrval,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= clrval;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_decode_pipe.sv
// rtl/fetch_decode_pipe.sv - PC, IF/ID and ID/EX state with hazard stall/flush handling
module fetch_decode_pipe
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallf,
    input  logic                 stalld,
    input  logic                 flushd,
    input  logic                 flushe,
    input  logic [31:0]          pcnextf,
    input  logic [31:0]          instrf,
    input  logic [31:0]          pcplus4f,
    input  logic                 regwrited,
    input  logic                 resultsrcd,
    input  logic                 memwrited,
    input  logic                 branchd,
    input  logic                 jumpd,
    input  logic [31:0]          rd1d,
    input  logic [31:0]          rd2d,
    input  logic [31:0]          immextd,
    output logic [31:0]          pcf,
    output logic [31:0]          instrd,
    output logic [31:0]          pcd,
    output logic [31:0]          pcplus4d,
    output logic [4:0]           rs1d,
    output logic [4:0]           rs2d,
    output logic [4:0]           rdd,
    output logic                 validd,
    output logic                 valide,
    output logic [4:0]           rs1e,
    output logic [4:0]           rs2e,
    output logic [4:0]           rde,
    output logic                 regwritee,
    output logic                 resultsrce,
    output logic                 memwritee,
    output logic                 branche,
    output logic                 jumpe,
    output logic [31:0]          rd1e,
    output logic [31:0]          rd2e,
    output logic [31:0]          immexte,
    output logic [31:0]          pce,
    output logic [31:0]          pcplus4e,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic                 ctrl_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    ifid_t ifid_d, ifid_q, ifid_bubble;
    idex_t idex_d, idex_q;

    pipe_reg #(.W(32)) u_pc (
        .clk(clk), .en(!stallf), .clr(rst), .clrval(RESET_PC), .d(pcnextf), .q(pcf)
    );

    always_comb begin
        ifid_bubble         = '0;
        ifid_bubble.instr   = NOP_INSTR;
        ifid_d.valid        = 1'b1;
        ifid_d.instr        = instrf;
        ifid_d.pc           = pcf;
        ifid_d.pcplus4      = pcplus4f;
    end

    // Flush outranks stall: a taken branch must squash even a held instruction.
    pipe_reg #(.W($bits(ifid_t))) u_ifid (
        .clk(clk), .en(!stalld), .clr(rst || flushd), .clrval(ifid_bubble),
        .d(ifid_d), .q(ifid_q)
    );

    assign instrd   = ifid_q.instr;
    assign pcd      = ifid_q.pc;
    assign pcplus4d = ifid_q.pcplus4;
    assign validd   = ifid_q.valid;
    assign rs1d     = instrd[RS1_HI:RS1_LO];
    assign rs2d     = instrd[RS2_HI:RS2_LO];
    assign rdd      = instrd[RD_HI:RD_LO];

    always_comb begin
        idex_d.valid         = validd;
        idex_d.ctrl.regwrite = regwrited;
        idex_d.ctrl.resultsrc = resultsrcd;
        idex_d.ctrl.memwrite = memwrited;
        idex_d.ctrl.branch   = branchd;
        idex_d.ctrl.jump     = jumpd;
        idex_d.rs1           = rs1d;
        idex_d.rs2           = rs2d;
        idex_d.rd            = rdd;
        idex_d.rd1           = rd1d;
        idex_d.rd2           = rd2d;
        idex_d.immext        = immextd;
        idex_d.pc            = pcd;
        idex_d.pcplus4       = pcplus4d;
    end

    // An all-zero bubble also zeroes register addresses so forwarding never matches it.
    pipe_reg #(.W($bits(idex_t))) u_idex (
        .clk(clk), .en(1'b1), .clr(rst || flushe), .clrval('0), .d(idex_d), .q(idex_q)
    );

    assign valide     = idex_q.valid;
    assign regwritee  = idex_q.ctrl.regwrite;
    assign resultsrce = idex_q.ctrl.resultsrc;
    assign memwritee  = idex_q.ctrl.memwrite;
    assign branche    = idex_q.ctrl.branch;
    assign jumpe      = idex_q.ctrl.jump;
    assign rs1e       = idex_q.rs1;
    assign rs2e       = idex_q.rs2;
    assign rde        = idex_q.rd;
    assign rd1e       = idex_q.rd1;
    assign rd2e       = idex_q.rd2;
    assign immexte    = idex_q.immext;
    assign pce        = idex_q.pc;
    assign pcplus4e   = idex_q.pcplus4;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            ctrl_err  <= 1'b0;
        end else begin
            if (stalld && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (flushd && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
            if ((stalld && !flushe) || (stallf != stalld)) begin
                ctrl_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// tb/tb_fetch_decode_pipe.sv - randomized self-checking bench for fetch_decode_pipe
module tb_fetch_decode_pipe;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = 4'd15;

    logic clk = 1'b0;
    logic rst, stallf, stalld, flushd, flushe;
    logic [31:0] pcnextf, instrf, pcplus4f, rd1d, rd2d, immextd;
    logic regwrited, resultsrcd, memwrited, branchd, jumpd;
    logic [31:0] pcf, instrd, pcd, pcplus4d, rd1e, rd2e, immexte, pce, pcplus4e;
    logic [4:0] rs1d, rs2d, rdd, rs1e, rs2e, rde;
    logic validd, valide, regwritee, resultsrce, memwritee, branche, jumpe, ctrl_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state, advanced once per clock from the documented rules.
    logic [31:0] m_pc, m_instrd, m_pcd, m_pcp4d;
    logic        m_validd, m_valide;
    logic [4:0]  m_ctrl;
    logic [4:0]  m_rs1e, m_rs2e, m_rde;
    logic [31:0] m_rd1e, m_rd2e, m_imme, m_pce, m_pcp4e;
    int          m_scnt, m_fcnt;
    logic        m_err;

    always #5 clk = ~clk;

    fetch_decode_pipe #(.RESET_PC(32'h0), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .stallf(stallf), .stalld(stalld), .flushd(flushd), .flushe(flushe),
        .pcnextf(pcnextf), .instrf(instrf), .pcplus4f(pcplus4f),
        .regwrited(regwrited), .resultsrcd(resultsrcd), .memwrited(memwrited),
        .branchd(branchd), .jumpd(jumpd), .rd1d(rd1d), .rd2d(rd2d), .immextd(immextd),
        .pcf(pcf), .instrd(instrd), .pcd(pcd), .pcplus4d(pcplus4d),
        .rs1d(rs1d), .rs2d(rs2d), .rdd(rdd), .validd(validd), .valide(valide),
        .rs1e(rs1e), .rs2e(rs2e), .rde(rde), .regwritee(regwritee), .resultsrce(resultsrce),
        .memwritee(memwritee), .branche(branche), .jumpe(jumpe),
        .rd1e(rd1e), .rd2e(rd2e), .immexte(immexte), .pce(pce), .pcplus4e(pcplus4e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .ctrl_err(ctrl_err)
    );

    task automatic clear_ctrl();
        rst = 0; stallf = 0; stalld = 0; flushd = 0; flushe = 0;
    endtask

    task automatic rand_data();
        instrf = $urandom; pcplus4f = $urandom; rd1d = $urandom; rd2d = $urandom;
        immextd = $urandom;
        {regwrited, resultsrcd, memwrited, branchd, jumpd} = 5'($urandom);
    endtask

    task automatic tick();
        logic [31:0] n_pc;
        n_pc = rst ? 32'h0 : (stallf ? m_pc : pcnextf);
        if (rst || flushe) begin
            m_valide = 0; m_ctrl = 0; m_rs1e = 0; m_rs2e = 0; m_rde = 0;
            m_rd1e = 0; m_rd2e = 0; m_imme = 0; m_pce = 0; m_pcp4e = 0;
        end else begin
            m_valide = m_validd;
            m_ctrl   = {regwrited, resultsrcd, memwrited, branchd, jumpd};
            m_rs1e   = m_instrd[19:15]; m_rs2e = m_instrd[24:20]; m_rde = m_instrd[11:7];
            m_rd1e = rd1d; m_rd2e = rd2d; m_imme = immextd; m_pce = m_pcd; m_pcp4e = m_pcp4d;
        end
        if (rst || flushd) begin
            m_instrd = 32'h13; m_pcd = 0; m_pcp4d = 0; m_validd = 0;
        end else if (!stalld) begin
            m_instrd = instrf; m_pcd = m_pc; m_pcp4d = pcplus4f; m_validd = 1;
        end
        if (rst) begin
            m_scnt = 0; m_fcnt = 0; m_err = 0;
        end else begin
            if (stalld && m_scnt < 15) m_scnt++;
            if (flushd && m_fcnt < 15) m_fcnt++;
            if ((stalld && !flushe) || (stallf != stalld)) m_err = 1;
        end
        m_pc = n_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_ctrl();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_ctrl(); rand_data(); pcnextf = 32'h40;
        rst = 1; tick(); tick(); rst = 0;
        checks++; if (pcf !== 32'h0) begin errors++; $display("FAIL reset_pcf got %h exp 0", pcf); end
        checks++; if (instrd !== 32'h13) begin errors++; $display("FAIL reset_instrd got %h exp 13", instrd); end
        checks++; if ({validd, valide} !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", {validd, valide}); end
        checks++; if ({stall_cnt, flush_cnt, ctrl_err} !== '0) begin errors++;
            $display("FAIL reset_cnt got %0d/%0d/%b exp 0/0/0", stall_cnt, flush_cnt, ctrl_err); end
        checks++; if ({rde, regwritee, memwritee, pce} !== '0) begin errors++; $display("FAIL reset_idex got rd=%0d pce=%h exp 0", rde, pce); end
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 3; k++) begin
            clear_ctrl(); rand_data();
            instrf = instrf | 32'h0000_0080;
            pcnextf = 32'(4 * k);
            tick();
            checks++; if (pcf !== 32'(4 * k)) begin errors++; $display("FAIL seq_pcf%0d got %h exp %h", k, pcf, 4 * k); end
            checks++; if (pcd !== 32'(4 * (k - 1))) begin errors++; $display("FAIL seq_pcd%0d got %h exp %h", k, pcd, 4 * (k - 1)); end
            checks++; if (valide !== (k >= 2)) begin errors++; $display("FAIL seq_valide%0d got %b exp %b", k, valide, k >= 2); end
        end
    endtask

    task automatic test_load_use();
        logic [31:0] pc0, ins0;
        int s0;
        pc0 = pcf; ins0 = instrd; s0 = m_scnt;
        clear_ctrl(); rand_data(); regwrited = 1;
        stallf = 1; stalld = 1; flushe = 1; pcnextf = 32'h999;
        tick();
        checks++; if (pcf !== pc0) begin errors++; $display("FAIL lu_pcf got %h exp %h", pcf, pc0); end
        checks++; if (instrd !== ins0) begin errors++; $display("FAIL lu_instrd got %h exp %h", instrd, ins0); end
        checks++; if ({rde, regwritee, valide} !== '0) begin errors++; $display("FAIL lu_bubble got rd=%0d rw=%b v=%b exp 0", rde, regwritee, valide); end
        checks++; if (stall_cnt !== CW'(s0 + 1)) begin errors++; $display("FAIL lu_stallcnt got %0d exp %0d", stall_cnt, s0 + 1); end
        checks++; if (ctrl_err !== 1'b0) begin errors++; $display("FAIL lu_err got %b exp 0", ctrl_err); end
    endtask

    task automatic test_branch();
        int f0;
        f0 = m_fcnt;
        clear_ctrl(); rand_data(); flushd = 1; flushe = 1; pcnextf = 32'h100;
        tick();
        checks++; if (instrd !== 32'h13 || validd !== 1'b0 || valide !== 1'b0) begin errors++;
            $display("FAIL br_bubble got %h/%b/%b exp 13/0/0", instrd, validd, valide); end
        checks++; if (flush_cnt !== CW'(f0 + 1)) begin errors++; $display("FAIL br_flushcnt got %0d exp %0d", flush_cnt, f0 + 1); end
        checks++; if (pcf !== 32'h100) begin errors++; $display("FAIL br_pcf got %h exp 100", pcf); end
    endtask

    task automatic test_simultaneous();
        int s0, f0;
        clear_ctrl(); rand_data(); pcnextf = 32'h200; tick();
        s0 = m_scnt; f0 = m_fcnt;
        rand_data(); stallf = 1; stalld = 1; flushd = 1; flushe = 1;
        tick();
        checks++; if (instrd !== 32'h13 || validd !== 1'b0) begin errors++;
            $display("FAIL sim_ifid got %h/%b exp 13/0", instrd, validd); end
        checks++; if (stall_cnt !== CW'(s0 + 1) || flush_cnt !== CW'(f0 + 1)) begin errors++;
            $display("FAIL sim_cnts got %0d/%0d exp %0d/%0d", stall_cnt, flush_cnt, s0 + 1, f0 + 1); end
        checks++; if (pcf !== 32'h200) begin errors++; $display("FAIL sim_pcf got %h exp 200", pcf); end
    endtask

    task automatic test_protocol();
        do_reset();
        stallf = 1; stalld = 1; tick();
        checks++; if (ctrl_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", ctrl_err); end
        clear_ctrl(); tick(); tick(); tick();
        checks++; if (ctrl_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", ctrl_err); end
        do_reset();
        checks++; if (ctrl_err !== 1'b0) begin errors++; $display("FAIL err_clr got %b exp 0", ctrl_err); end
        stallf = 1; tick(); stallf = 0;
        checks++; if (ctrl_err !== 1'b1) begin errors++; $display("FAIL err_mismatch got %b exp 1", ctrl_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        stallf = 1; stalld = 1; flushe = 1;
        for (int i = 1; i <= 20; i++) begin
            rand_data(); tick();
            if (i == 14 || i == 15 || i == 20) begin
                checks++;
                if (stall_cnt !== CW'((i > 15) ? 15 : i)) begin errors++;
                    $display("FAIL sat_%0d got %0d exp %0d", i, stall_cnt, (i > 15) ? 15 : i); end
            end
        end
        checks++; if (stall_cnt !== CMAX) begin errors++; $display("FAIL sat_final got %0d exp 15", stall_cnt); end
        clear_ctrl();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_data(); pcnextf = $urandom;
            rst    = ($urandom_range(0, 29) == 0);
            stalld = ($urandom_range(0, 3) == 0);
            stallf = ($urandom_range(0, 19) == 0) ? !stalld : stalld;
            flushd = ($urandom_range(0, 4) == 0);
            flushe = stalld ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 4) == 0);
            tick();
            checks++; if (pcf !== m_pc) begin errors++; $display("FAIL rnd_pcf cyc %0d got %h exp %h", i, pcf, m_pc); end
            checks++; if ({validd, instrd, pcd, pcplus4d} !== {m_validd, m_instrd, m_pcd, m_pcp4d}) begin errors++;
                $display("FAIL rnd_ifid cyc %0d got %b %h %h %h exp %b %h %h %h", i, validd, instrd, pcd, pcplus4d,
                         m_validd, m_instrd, m_pcd, m_pcp4d); end
            checks++; if ({rs1d, rs2d, rdd} !== {m_instrd[19:15], m_instrd[24:20], m_instrd[11:7]}) begin errors++;
                $display("FAIL rnd_dec cyc %0d got %0d %0d %0d", i, rs1d, rs2d, rdd); end
            checks++; if ({valide, regwritee, resultsrce, memwritee, branche, jumpe, rs1e, rs2e, rde}
                          !== {m_valide, m_ctrl, m_rs1e, m_rs2e, m_rde}) begin errors++;
                $display("FAIL rnd_idex_ctl cyc %0d got %b %b %0d %0d %0d exp %b %b %0d %0d %0d", i, valide,
                         {regwritee, resultsrce, memwritee, branche, jumpe}, rs1e, rs2e, rde,
                         m_valide, m_ctrl, m_rs1e, m_rs2e, m_rde); end
            checks++; if ({rd1e, rd2e, immexte, pce, pcplus4e} !== {m_rd1e, m_rd2e, m_imme, m_pce, m_pcp4e}) begin errors++;
                $display("FAIL rnd_idex_data cyc %0d got pce=%h rd1e=%h exp pce=%h rd1e=%h", i, pce, rd1e, m_pce, m_rd1e); end
            checks++; if ({stall_cnt, flush_cnt, ctrl_err} !== {CW'(m_scnt), CW'(m_fcnt), m_err}) begin errors++;
                $display("FAIL rnd_cnt cyc %0d got %0d %0d %b exp %0d %0d %b", i, stall_cnt, flush_cnt, ctrl_err,
                         m_scnt, m_fcnt, m_err); end
        end
    endtask

    initial begin
        m_pc = 0; m_instrd = 32'h13; m_pcd = 0; m_pcp4d = 0; m_validd = 0; m_valide = 0;
        m_ctrl = 0; m_rs1e = 0; m_rs2e = 0; m_rde = 0; m_rd1e = 0; m_rd2e = 0; m_imme = 0;
        m_pce = 0; m_pcp4e = 0; m_scnt = 0; m_fcnt = 0; m_err = 0;
        clear_ctrl(); rand_data(); pcnextf = 0;
        #1;
        test_reset();
        test_sequential();
        test_load_use();
        test_branch();
        test_simultaneous();
        test_protocol();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
